// File: rtl/hilo_ctrl_pkg.sv
// Shared constants, op/state encodings and write payload for the HI/LO sequencer.
package hilo_ctrl_pkg;

    localparam int unsigned HILO_W      = 32;
    localparam int unsigned HILO_DIV_IT = HILO_W;
    localparam int unsigned HILO_CNT_W  = $clog2(HILO_DIV_IT);

    typedef enum logic [2:0] {
        HILO_OP_NOP   = 3'd0,
        HILO_OP_MULT  = 3'd1,
        HILO_OP_MULTU = 3'd2,
        HILO_OP_DIV   = 3'd3,
        HILO_OP_DIVU  = 3'd4,
        HILO_OP_MTHI  = 3'd5,
        HILO_OP_MTLO  = 3'd6
    } hilo_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } hilo_state_e;

    typedef struct packed {
        logic [HILO_W-1:0] hi;
        logic [HILO_W-1:0] lo;
    } hilo_wr_t;

    // Two's-complement negate when sgn is set (magnitude in, signed value out or vice versa).
    function automatic logic [HILO_W-1:0] apply_sign(input logic [HILO_W-1:0] x, input logic sgn);
        return sgn ? HILO_W'(-x) : x;
    endfunction

endpackage

// File: rtl/hilo_ctrl_div_iter.sv
// Unsigned restoring divider: one quotient bit per step, dividend shifts out as quotient shifts in.
module hilo_ctrl_div_iter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic         step_i,
    input  logic [W-1:0] dvd_i,
    input  logic [W-1:0] dvs_i,
    output logic [W-1:0] quo_o,
    output logic [W-1:0] rem_o
);

    logic [W-1:0] quo_q;
    logic [W-1:0] rem_q;
    logic [W-1:0] dvs_q;
    logic [W:0]   rem_sh;
    logic [W-1:0] diff;
    logic         ge;

    // rem_q < dvs_q holds between steps, so the true difference always fits in W bits.
    assign rem_sh = {rem_q, quo_q[W-1]};
    assign ge     = rem_sh >= {1'b0, dvs_q};
    assign diff   = rem_sh[W-1:0] - dvs_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
        end else if (start_i) begin
            quo_q <= dvd_i;
            rem_q <= '0;
            dvs_q <= dvs_i;
        end else if (step_i) begin
            quo_q <= {quo_q[W-2:0], ge};
            rem_q <= ge ? diff : rem_sh[W-1:0];
        end
    end

    assign quo_o = quo_q;
    assign rem_o = rem_q;

endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO sequencer: accepts mult/div/mt ops from EX, stalls while busy, issues one write strobe.
module hilo_ctrl
    import hilo_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid_i,
    input  logic [2:0]        op_i,
    input  logic [HILO_W-1:0] src_a_i,
    input  logic [HILO_W-1:0] src_b_i,
    input  logic              flush_i,
    input  logic [HILO_W-1:0] hi_cur_i,
    input  logic [HILO_W-1:0] lo_cur_i,
    output logic              stall_o,
    output logic              busy_o,
    output logic              hilo_we_o,
    output logic [HILO_W-1:0] hi_wdata_o,
    output logic [HILO_W-1:0] lo_wdata_o
);

    localparam int unsigned PW = 2 * HILO_W;

    hilo_state_e           state_q, state_d;
    logic [HILO_CNT_W-1:0] cnt_q, cnt_d;
    logic [HILO_W-1:0]     mul_a_q, mul_a_d;
    logic [HILO_W-1:0]     mul_b_q, mul_b_d;
    logic                  mul_sgn_q, mul_sgn_d;
    logic                  sa_q, sa_d;
    logic                  sb_q, sb_d;
    logic                  dvz_q, dvz_d;

    logic                  abort;
    logic                  div_start;
    logic                  div_step;
    logic                  div_sgn;
    logic [HILO_W-1:0]     div_dvd;
    logic [HILO_W-1:0]     div_dvs;
    logic [HILO_W-1:0]     quo;
    logic [HILO_W-1:0]     rem;
    logic [PW-1:0]         mul_ext_a;
    logic [PW-1:0]         mul_ext_b;
    logic [PW-1:0]         product;
    logic                  stall_c;
    logic                  we_c;
    hilo_wr_t              wr_c;

    // Sign-extend for MULT, zero-extend for MULTU; the low 2W bits are then correct for both.
    assign mul_ext_a = {{HILO_W{mul_sgn_q & mul_a_q[HILO_W-1]}}, mul_a_q};
    assign mul_ext_b = {{HILO_W{mul_sgn_q & mul_b_q[HILO_W-1]}}, mul_b_q};
    assign product   = mul_ext_a * mul_ext_b;

    assign div_sgn = (op_i == HILO_OP_DIV);
    assign div_dvd = apply_sign(src_a_i, div_sgn & src_a_i[HILO_W-1]);
    assign div_dvs = apply_sign(src_b_i, div_sgn & src_b_i[HILO_W-1]);

    hilo_ctrl_div_iter #(
        .W (HILO_W)
    ) u_div (
        .clk     (clk),
        .rst     (rst),
        .start_i (div_start),
        .step_i  (div_step),
        .dvd_i   (div_dvd),
        .dvs_i   (div_dvs),
        .quo_o   (quo),
        .rem_o   (rem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            mul_sgn_q <= 1'b0;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            dvz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mul_a_q   <= mul_a_d;
            mul_b_q   <= mul_b_d;
            mul_sgn_q <= mul_sgn_d;
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            dvz_q     <= dvz_d;
        end
    end

    // Reset mid-operation is handled exactly like flush on the combinational side.
    assign abort = flush_i | rst;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        mul_sgn_d = mul_sgn_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        dvz_d     = dvz_q;
        div_start = 1'b0;
        div_step  = 1'b0;
        stall_c   = 1'b0;
        we_c      = 1'b0;
        wr_c      = '0;

        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (op_valid_i) begin
                        case (op_i)
                            HILO_OP_MULT, HILO_OP_MULTU: begin
                                mul_a_d   = src_a_i;
                                mul_b_d   = src_b_i;
                                mul_sgn_d = (op_i == HILO_OP_MULT);
                                stall_c   = 1'b1;
                                state_d   = ST_MUL;
                            end
                            HILO_OP_DIV, HILO_OP_DIVU: begin
                                sa_d      = div_sgn & src_a_i[HILO_W-1];
                                sb_d      = div_sgn & src_b_i[HILO_W-1];
                                dvz_d     = (src_b_i == '0);
                                cnt_d     = '0;
                                div_start = 1'b1;
                                stall_c   = 1'b1;
                                state_d   = ST_DIV;
                            end
                            HILO_OP_MTHI: begin
                                we_c    = 1'b1;
                                wr_c.hi = src_a_i;
                                wr_c.lo = lo_cur_i;
                            end
                            HILO_OP_MTLO: begin
                                we_c    = 1'b1;
                                wr_c.hi = hi_cur_i;
                                wr_c.lo = src_a_i;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    we_c    = 1'b1;
                    wr_c    = hilo_wr_t'(product);
                    state_d = ST_IDLE;
                end
                ST_DIV: begin
                    stall_c  = 1'b1;
                    div_step = 1'b1;
                    cnt_d    = cnt_q + HILO_CNT_W'(1);
                    if (cnt_q == HILO_CNT_W'(HILO_DIV_IT - 1)) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    we_c    = 1'b1;
                    wr_c.lo = dvz_q ? '1 : apply_sign(quo, sa_q ^ sb_q);
                    wr_c.hi = apply_sign(rem, sa_q);
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign stall_o    = stall_c;
    assign busy_o     = (state_q != ST_IDLE);
    assign hilo_we_o  = we_c;
    assign hi_wdata_o = wr_c.hi;
    assign lo_wdata_o = wr_c.lo;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed and randomized checks of hilo_ctrl against an arithmetic reference model.
module tb_hilo_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid_i;
    logic [2:0]  op_i;
    logic [31:0] src_a_i;
    logic [31:0] src_b_i;
    logic        flush_i;
    logic [31:0] hi_cur_i;
    logic [31:0] lo_cur_i;
    logic        stall_o;
    logic        busy_o;
    logic        hilo_we_o;
    logic [31:0] hi_wdata_o;
    logic [31:0] lo_wdata_o;

    int total = 0;
    int bad   = 0;
    int we_cnt = 0;

    hilo_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid_i (op_valid_i),
        .op_i       (op_i),
        .src_a_i    (src_a_i),
        .src_b_i    (src_b_i),
        .flush_i    (flush_i),
        .hi_cur_i   (hi_cur_i),
        .lo_cur_i   (lo_cur_i),
        .stall_o    (stall_o),
        .busy_o     (busy_o),
        .hilo_we_o  (hilo_we_o),
        .hi_wdata_o (hi_wdata_o),
        .lo_wdata_o (lo_wdata_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (hilo_we_o) we_cnt <= we_cnt + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: results straight from the instruction definitions.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, b, hic, loc);
        longint          sp;
        longint unsigned up;
        logic            na, nb;
        logic [31:0]     ma, mb, q, r, hi, lo;
        case (o)
            3'd1: begin sp = longint'($signed(a)) * longint'($signed(b)); return 64'(sp); end
            3'd2: begin up = 64'(a) * 64'(b); return up; end
            3'd3, 3'd4: begin
                na = (o == 3'd3) && $signed(a) < 0;
                nb = (o == 3'd3) && $signed(b) < 0;
                ma = na ? 32'(0 - a) : a;
                mb = nb ? 32'(0 - b) : b;
                if (mb == 0) begin
                    q = 32'hFFFF_FFFF; r = ma;
                    lo = q;
                end else begin
                    q = ma / mb; r = ma % mb;
                    lo = (na != nb) ? 32'(0 - q) : q;
                end
                hi = na ? 32'(0 - r) : r;
                return {hi, lo};
            end
            3'd5: return {a, loc};
            3'd6: return {hic, a};
            default: return 64'd0;
        endcase
    endfunction

    function automatic int exp_stalls(input logic [2:0] o);
        if (o == 3'd1 || o == 3'd2) return 1;
        if (o == 3'd3 || o == 3'd4) return 33;
        return 0;
    endfunction

    // Issue one op as EX would (held while stalled); starts and ends just after a rising edge.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, b, input string tag,
                         output logic [31:0] ohi, output logic [31:0] olo);
        int ns = 0;
        int budget = 0;
        bit got = 0;
        logic [63:0] exp;
        exp = model(o, a, b, hi_cur_i, lo_cur_i);
        ohi = '0;
        olo = '0;
        op_valid_i = 1'b1; op_i = o; src_a_i = a; src_b_i = b;
        while (!got && budget < 60) begin
            @(negedge clk);
            if (hilo_we_o) begin
                got = 1;
                ohi = hi_wdata_o;
                olo = lo_wdata_o;
                check({tag, "_wr_stall"}, 64'(stall_o), 64'd0);
            end else if (stall_o) begin
                ns++;
            end
            @(posedge clk); #1;
            budget++;
        end
        op_valid_i = 1'b0; op_i = 3'd0;
        check({tag, "_got_we"}, 64'(got), 64'd1);
        check({tag, "_stalls"}, 64'(ns), 64'(exp_stalls(o)));
        check({tag, "_model"}, {ohi, olo}, exp);
        @(negedge clk);
        check({tag, "_single_we"}, 64'(hilo_we_o), 64'd0);
        check({tag, "_idle"}, 64'(busy_o), 64'd0);
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] h, l;
        int base;

        rst = 1'b1; op_valid_i = 1'b0; op_i = 3'd0; src_a_i = '0; src_b_i = '0;
        flush_i = 1'b0; hi_cur_i = 32'hA5A5_0001; lo_cur_i = 32'h55;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_stall", 64'(stall_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_we", 64'(hilo_we_o), 64'd0);
        check("rst_data", {hi_wdata_o, lo_wdata_o}, 64'd0);
        @(posedge clk); #1;

        do_op(3'd5, 32'h1234, 32'h0, "mthi", h, l);
        check("mthi_val", {h, l}, {32'h1234, 32'h55});

        do_op(3'd1, 32'hFFFF_FFFE, 32'd3, "mult", h, l);
        check("mult_val", {h, l}, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
        do_op(3'd2, 32'hFFFF_FFFE, 32'd3, "multu", h, l);
        check("multu_val", {h, l}, {32'h2, 32'hFFFF_FFFA});

        do_op(3'd3, 32'hFFFF_FFF9, 32'd2, "div", h, l);
        check("div_val", {h, l}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        do_op(3'd4, 32'd100, 32'd7, "divu", h, l);
        check("divu_val", {h, l}, {32'd2, 32'd14});
        do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", h, l);
        check("div_ovf_val", {h, l}, {32'h0, 32'h8000_0000});
        do_op(3'd4, 32'd5, 32'd0, "divu_z", h, l);
        check("divu_z_val", {h, l}, {32'd5, 32'hFFFF_FFFF});

        // Flush on DIV cycle 10.
        base = we_cnt;
        op_valid_i = 1'b1; op_i = 3'd3; src_a_i = 32'd1000; src_b_i = 32'd3;
        repeat (9) begin @(posedge clk); #1; end
        @(negedge clk);
        check("fl_busy_before", 64'(busy_o), 64'd1);
        check("fl_stall_before", 64'(stall_o), 64'd1);
        flush_i = 1'b1; #1;
        check("fl_stall", 64'(stall_o), 64'd0);
        check("fl_we", 64'(hilo_we_o), 64'd0);
        @(posedge clk); #1 flush_i = 1'b0; op_valid_i = 1'b0; op_i = 3'd0;
        @(negedge clk);
        check("fl_busy_after", 64'(busy_o), 64'd0);
        check("fl_stall_after", 64'(stall_o), 64'd0);
        repeat (40) @(posedge clk); #1;
        check("fl_no_we", 64'(we_cnt - base), 64'd0);
        do_op(3'd2, 32'h0001_0000, 32'h0003_0000, "fl_multu", h, l);
        check("fl_multu_val", {h, l}, {32'h3, 32'h0});

        // Flush in IDLE blocks acceptance of an MTHI.
        base = we_cnt;
        op_valid_i = 1'b1; op_i = 3'd5; src_a_i = 32'hDEAD; flush_i = 1'b1;
        @(negedge clk);
        check("fl_idle_we", 64'(hilo_we_o), 64'd0);
        @(posedge clk); #1 flush_i = 1'b0; op_valid_i = 1'b0; op_i = 3'd0;
        @(negedge clk);
        check("fl_idle_busy", 64'(busy_o), 64'd0);
        @(posedge clk); #1;
        check("fl_idle_cnt", 64'(we_cnt - base), 64'd0);

        // Reset on DIV cycle 20.
        base = we_cnt;
        op_valid_i = 1'b1; op_i = 3'd4; src_a_i = 32'd77; src_b_i = 32'd5;
        repeat (19) begin @(posedge clk); #1; end
        rst = 1'b1; #1;
        check("rs_stall", 64'(stall_o), 64'd0);
        check("rs_we", 64'(hilo_we_o), 64'd0);
        @(posedge clk); #1 rst = 1'b0; op_valid_i = 1'b0; op_i = 3'd0;
        @(negedge clk);
        check("rs_outs", {28'd0, stall_o, busy_o, hilo_we_o, 1'b0, hi_wdata_o ^ lo_wdata_o},
              64'd0);
        check("rs_data", {hi_wdata_o, lo_wdata_o}, 64'd0);
        repeat (40) @(posedge clk); #1;
        check("rs_no_we", 64'(we_cnt - base), 64'd0);

        // Back-to-back DIVU then MTLO.
        base = we_cnt;
        do_op(3'd4, 32'hFFFF_FFFF, 32'd16, "b2b_divu", h, l);
        check("b2b_divu_val", {h, l}, {32'hF, 32'h0FFF_FFFF});
        check("b2b_cnt1", 64'(we_cnt - base), 64'd1);
        do_op(3'd6, 32'hCAFE_F00D, 32'd0, "b2b_mtlo", h, l);
        check("b2b_mtlo_val", {h, l}, {32'hA5A5_0001, 32'hCAFE_F00D});
        check("b2b_cnt2", 64'(we_cnt - base), 64'd2);

        // Randomized ops against the model.
        for (int i = 0; i < 40; i++) begin
            logic [2:0] ro;
            ro = 3'($urandom_range(1, 6));
            hi_cur_i = $urandom;
            lo_cur_i = $urandom;
            do_op(ro, rnd_val(), rnd_val(), $sformatf("rnd%0d_op%0d", i, ro), h, l);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
